// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared constants for the binary32 add/sub datapath.
//   - field widths, bias, canonical quiet NaN, all-ones exponent
//   - bit positions inside the pre-alignment exception vector
//   - bit positions inside the packer status flags
package fpaddsub_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MANT_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  // Exception vector layout: {any, ANaN, BNaN, AInf, BInf}
  typedef enum int unsigned {
    EXC_BINF = 0,
    EXC_AINF = 1,
    EXC_BNAN = 2,
    EXC_ANAN = 3,
    EXC_ANY  = 4
  } exc_idx_e;

  // Flag layout: {invalid, overflow, underflow, inexact}
  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

endpackage

// File: rtl/fpaddsub_round_unit.sv
// fpaddsub_round_unit: combinational rounding increment.
//   mant  in  24  normalized significand, hidden bit at [23]
//   grs   in   3  guard, round, sticky
//   sum   out 25  mant + rounding increment; bit 24 is the rounding carry
// Build option: FPADDSUB_ROUND_NEAREST_EN defined selects round-to-nearest-
// even; undefined selects truncation (no increment).
module fpaddsub_round_unit
  import fpaddsub_pkg::*;
(
  input  logic [MANT_W:0]   mant,
  input  logic [2:0]        grs,
  output logic [MANT_W+1:0] sum
);

  logic rnd_up;

`ifdef FPADDSUB_ROUND_NEAREST_EN
  // Round up above half, or on an exact tie when the LSB is odd.
  assign rnd_up = grs[2] & (grs[1] | grs[0] | mant[0]);
`else
  logic unused_grs;
  assign unused_grs = ^grs;
  assign rnd_up     = 1'b0;
`endif

  assign sum = {1'b0, mant} + {{(MANT_W+1){1'b0}}, rnd_up};

endmodule

// File: rtl/fpaddsub_result_packer.sv
// fpaddsub_result_packer: final stage of the binary32 add/sub datapath.
// Stage 1 rounds the normalized significand; stage 2 resolves special
// cases, post-normalizes after rounding and packs the IEEE word + flags.
// Both stages share one stall signal (adv), so a blocked output freezes
// the whole pipe, including an empty stage 1.
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     input handshake
//   in_sign/exp/mant/grs  normalized result from the normalizer
//   in_exc                {any, ANaN, BNaN, AInf, BInf}
//   in_sa/in_sb/in_op     original operand signs and operation (1 = sub)
//   out_valid/out_ready   output handshake
//   out_data              packed binary32 result
//   out_flags             {invalid, overflow, underflow, inexact}
// Build option: FPADDSUB_ROUND_NEAREST_EN (see fpaddsub_round_unit).
module fpaddsub_result_packer
  import fpaddsub_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [23:0] in_mant,
  input  logic [2:0]  in_grs,
  input  logic [4:0]  in_exc,
  input  logic        in_sa,
  input  logic        in_sb,
  input  logic        in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags
);

  logic        adv;
  logic [24:0] rnd_sum;

  logic        s1_valid;
  logic        s1_sign;
  logic [8:0]  s1_exp;
  logic [4:0]  s1_exc;
  logic        s1_sa;
  logic        s1_sb;
  logic        s1_op;
  logic [24:0] s1_sum;
  logic        s1_zero;
  logic        s1_inexact;

  logic [31:0] pk_data;
  logic [3:0]  pk_flags;
  logic [8:0]  exp_f;
  logic        eff_sub;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  fpaddsub_round_unit u_round (
    .mant (in_mant),
    .grs  (in_grs),
    .sum  (rnd_sum)
  );

  // Stage 1: round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_exc     <= '0;
      s1_sa      <= 1'b0;
      s1_sb      <= 1'b0;
      s1_op      <= 1'b0;
      s1_sum     <= '0;
      s1_zero    <= 1'b0;
      s1_inexact <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_exp     <= in_exp;
        s1_exc     <= in_exc;
        s1_sa      <= in_sa;
        s1_sb      <= in_sb;
        s1_op      <= in_op;
        s1_sum     <= rnd_sum;
        s1_zero    <= (in_mant == '0) && (in_grs == '0);
        s1_inexact <= |in_grs;
      end
    end
  end

  // Stage 2: special cases and pack
  assign eff_sub = s1_sa ^ s1_sb ^ s1_op;

  always_comb begin
    pk_data  = '0;
    pk_flags = '0;
    // A rounding carry means the significand became 2.0: bump the exponent.
    exp_f    = s1_sum[24] ? (s1_exp + 9'd1) : s1_exp;
    if (s1_exc[EXC_ANAN] | s1_exc[EXC_BNAN]) begin
      pk_data = QNAN;
    end else if (s1_exc[EXC_AINF] & s1_exc[EXC_BINF] & eff_sub) begin
      pk_data              = QNAN;
      pk_flags[FLG_INVALID] = 1'b1;
    end else if (s1_exc[EXC_AINF]) begin
      pk_data = {s1_sa, EXP_MAX, {MANT_W{1'b0}}};
    end else if (s1_exc[EXC_BINF]) begin
      pk_data = {s1_sb ^ s1_op, EXP_MAX, {MANT_W{1'b0}}};
    end else if (s1_zero) begin
      pk_data = {s1_sign, 31'd0};
    end else if ((exp_f >= 9'd255) || s1_exp[8]) begin
      // s1_exp[8] catches normalizer overflow even if the increment wrapped.
      pk_data                = {s1_sign, EXP_MAX, {MANT_W{1'b0}}};
      pk_flags[FLG_OVERFLOW] = 1'b1;
      pk_flags[FLG_INEXACT]  = 1'b1;
    end else if (exp_f == 9'd0) begin
      pk_data                 = {s1_sign, 31'd0};
      pk_flags[FLG_UNDERFLOW] = 1'b1;
      pk_flags[FLG_INEXACT]   = 1'b1;
    end else begin
      pk_data               = {s1_sign, exp_f[EXP_W-1:0],
                               s1_sum[24] ? {MANT_W{1'b0}} : s1_sum[MANT_W-1:0]};
      pk_flags[FLG_INEXACT] = s1_inexact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= pk_data;
        out_flags <= pk_flags;
      end
    end
  end

  // Hidden bit and the summary "any" exception bit carry no extra information.
  logic unused_bits;
  assign unused_bits = s1_sum[23] ^ s1_exc[EXC_ANY];

endmodule

// File: tb/tb_fpaddsub_result_packer.sv
module tb_fpaddsub_result_packer;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] mant;
    logic [2:0]  grs;
    logic [4:0]  exc;
    logic        sa;
    logic        sb;
    logic        op;
  } beat_t;

  typedef struct packed {
    beat_t       b;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic [35:0] val;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_sa, in_sb, in_op;
  logic [8:0]  in_exp;
  logic [23:0] in_mant;
  logic [2:0]  in_grs;
  logic [4:0]  in_exc;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  beat_t       cur;
  logic        cur_valid;
  logic        cur_rdy;
  logic [35:0] push_val;
  logic        acc;
  logic        lat_chk;
  exp_t        expq[$];
  vec_t        vecs[15];

  always #5 clk = ~clk;

  fpaddsub_result_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_grs    (in_grs),
    .in_exc    (in_exc),
    .in_sa     (in_sa),
    .in_sb     (in_sb),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  function automatic beat_t mkb(input logic s, input logic [8:0] e, input logic [23:0] m,
                                input logic [2:0] g, input logic [4:0] x,
                                input logic sa, input logic sb, input logic op);
    beat_t b;
    b.sign = s; b.exp = e; b.mant = m; b.grs = g; b.exc = x;
    b.sa = sa; b.sb = sb; b.op = op;
    return b;
  endfunction

  // Reference model: value-level rounding and IEEE packing rules.
  function automatic logic [35:0] model(input beat_t b);
    logic [31:0] m;
    logic [31:0] e;
    if (b.exc[3] || b.exc[2]) return {32'h7FC00000, 4'b0000};
    if (b.exc[1] && b.exc[0] && (b.sa ^ b.sb ^ b.op)) return {32'h7FC00000, 4'b1000};
    if (b.exc[1]) return {b.sa, 8'hFF, 23'd0, 4'b0000};
    if (b.exc[0]) return {b.sb ^ b.op, 8'hFF, 23'd0, 4'b0000};
    if (b.mant == 24'd0 && b.grs == 3'd0) return {b.sign, 31'd0, 4'b0000};
    m = {8'd0, b.mant};
    e = {23'd0, b.exp};
`ifdef FPADDSUB_ROUND_NEAREST_EN
    if (b.grs[2] && (b.grs[1] || b.grs[0] || (m % 2 == 1))) m = m + 1;
`endif
    if (m >= 32'h0100_0000) begin
      e = e + 1;
      m = m / 2;
    end
    if (e >= 255) return {b.sign, 8'hFF, 23'd0, 4'b0101};
    if (e == 0) return {b.sign, 31'd0, 4'b0011};
    return {b.sign, e[7:0], m[22:0], 3'b000, (b.grs != 3'd0)};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    logic [31:0] r;
    b.sign = 1'($urandom);
    b.sa   = 1'($urandom);
    b.sb   = 1'($urandom);
    b.op   = 1'($urandom);
    b.grs  = 3'($urandom);
    b.exc  = 5'd0;
    if ($urandom_range(0, 7) == 0) begin
      b.exc = 5'($urandom);
      b.exc[4] = (b.exc[3:0] != 4'd0);
    end
    r = $urandom_range(0, 9);
    case (r)
      0: b.exp = 9'($urandom);
      1: b.exp = 9'd0;
      2: b.exp = 9'd254;
      3: b.exp = 9'd255;
      default: b.exp = 9'($urandom_range(1, 254));
    endcase
    r = $urandom_range(0, 9);
    case (r)
      0: b.mant = 24'h000000;
      1: b.mant = 24'hFFFFFF;
      2: b.mant = 24'($urandom);
      default: b.mant = {1'b1, 23'($urandom)};
    endcase
    return b;
  endfunction

  // One clock: drive at negedge, then observe handshakes that the next edge commits.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    in_valid  = cur_valid;
    in_sign   = cur.sign;
    in_exp    = cur.exp;
    in_mant   = cur.mant;
    in_grs    = cur.grs;
    in_exc    = cur.exc;
    in_sa     = cur.sa;
    in_sb     = cur.sb;
    in_op     = cur.op;
    out_ready = cur_rdy;
    #1;
    cyc_n++;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h/%h required no output", out_data, out_flags);
      end else begin
        e = expq.pop_front();
        chk("result", {28'd0, out_data, out_flags}, {28'd0, e.val});
        if (lat_chk) chk("latency", 64'(cyc_n - e.acc), 64'd2);
      end
    end
    acc = 1'b0;
    if (in_valid && in_ready) begin
      e.val = push_val;
      e.acc = cyc_n;
      expq.push_back(e);
      acc = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    cur_valid = 1'b0;
    cur_rdy   = 1'b1;
    for (int k = 0; k < 12 && expq.size() != 0; k++) cyc();
    chk(name, 64'(expq.size()), 64'd0);
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{mkb(0, 9'd127, 24'h800000, 3'b000, 5'b00000, 0, 0, 0), 32'h3F800000, 4'b0000};
`ifdef FPADDSUB_ROUND_NEAREST_EN
    vecs[1]  = '{mkb(0, 9'd127, 24'hFFFFFF, 3'b100, 5'b00000, 0, 0, 0), 32'h40000000, 4'b0001};
    vecs[2]  = '{mkb(0, 9'd254, 24'hFFFFFF, 3'b110, 5'b00000, 0, 0, 0), 32'h7F800000, 4'b0101};
    vecs[13] = '{mkb(0, 9'd127, 24'h800001, 3'b100, 5'b00000, 0, 0, 0), 32'h3F800002, 4'b0001};
`else
    vecs[1]  = '{mkb(0, 9'd127, 24'hFFFFFF, 3'b100, 5'b00000, 0, 0, 0), 32'h3FFFFFFF, 4'b0001};
    vecs[2]  = '{mkb(0, 9'd254, 24'hFFFFFF, 3'b110, 5'b00000, 0, 0, 0), 32'h7F7FFFFF, 4'b0001};
    vecs[13] = '{mkb(0, 9'd127, 24'h800001, 3'b100, 5'b00000, 0, 0, 0), 32'h3F800001, 4'b0001};
`endif
    vecs[3]  = '{mkb(0, 9'd127, 24'h800000, 3'b000, 5'b10011, 0, 0, 1), 32'h7FC00000, 4'b1000};
    vecs[4]  = '{mkb(0, 9'd127, 24'h800000, 3'b000, 5'b10011, 0, 0, 0), 32'h7F800000, 4'b0000};
    vecs[5]  = '{mkb(0, 9'd127, 24'h800000, 3'b000, 5'b11000, 0, 0, 0), 32'h7FC00000, 4'b0000};
    vecs[6]  = '{mkb(0, 9'd127, 24'h800000, 3'b000, 5'b10001, 0, 0, 1), 32'hFF800000, 4'b0000};
    vecs[7]  = '{mkb(1, 9'd50,  24'h000000, 3'b000, 5'b00000, 0, 0, 0), 32'h80000000, 4'b0000};
    vecs[8]  = '{mkb(0, 9'h100, 24'h800000, 3'b000, 5'b00000, 0, 0, 0), 32'h7F800000, 4'b0101};
    vecs[9]  = '{mkb(1, 9'd0,   24'h800000, 3'b000, 5'b00000, 0, 0, 0), 32'h80000000, 4'b0011};
    vecs[10] = '{mkb(0, 9'd255, 24'h800000, 3'b000, 5'b00000, 0, 0, 0), 32'h7F800000, 4'b0101};
    vecs[11] = '{mkb(0, 9'd130, 24'hA00001, 3'b011, 5'b00000, 0, 0, 0), 32'h41200001, 4'b0001};
    vecs[12] = '{mkb(1, 9'd100, 24'hC00000, 3'b100, 5'b00000, 0, 0, 0), 32'hB2400000, 4'b0001};
    vecs[14] = '{mkb(0, 9'd127, 24'h800000, 3'b000, 5'b10010, 1, 0, 0), 32'hFF800000, 4'b0000};

    rst = 1'b1;
    cur = '0; cur_valid = 1'b0; cur_rdy = 1'b1; push_val = '0; lat_chk = 1'b1; acc = 1'b0;
    in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0; in_grs = 0; in_exc = 0;
    in_sa = 0; in_sb = 0; in_op = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", {32'd0, out_data}, 64'd0);
    chk("reset_out_flags", {60'd0, out_flags}, 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed table with strict 2-cycle latency
    for (int i = 0; i < 15; i++) begin
      cur = vecs[i].b;
      push_val = {vecs[i].data, vecs[i].flags};
      cur_valid = 1'b1;
      cur_rdy = 1'b1;
      cyc();
      chk("vec_accept", {63'd0, acc}, 64'd1);
      drain("vec_done");
    end
    lat_chk = 1'b0;

    // Backpressure: three beats, output blocked for four more cycles
    cur_rdy = 1'b0;
    cur_valid = 1'b1;
    cur = mkb(0, 9'd127, 24'h800000, 3'b000, 5'd0, 0, 0, 0); push_val = model(cur); cyc();
    chk("bp_accept0", {63'd0, acc}, 64'd1);
    cur = mkb(1, 9'd128, 24'hC00000, 3'b001, 5'd0, 0, 0, 0); push_val = model(cur); cyc();
    chk("bp_accept1", {63'd0, acc}, 64'd1);
    cur = mkb(0, 9'd200, 24'hABCDEF, 3'b111, 5'd0, 0, 0, 0); push_val = model(cur); cyc();
    chk("bp_block2", {63'd0, acc}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_stable", {32'd0, out_data}, {32'd0, expq[0].val[35:4]});
    end
    cur_rdy = 1'b1;
    cyc();
    chk("bp_accept2", {63'd0, acc}, 64'd1);
    drain("bp_all_out");

    // Reset with two beats in flight
    cur_rdy = 1'b0;
    cur_valid = 1'b1;
    cur = mkb(0, 9'd140, 24'h900000, 3'b000, 5'd0, 0, 0, 0); push_val = model(cur); cyc();
    cur = mkb(1, 9'd141, 24'h910000, 3'b000, 5'd0, 0, 0, 0); push_val = model(cur); cyc();
    cur_valid = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    expq.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    cur_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_no_out", {63'd0, out_valid}, 64'd0);
    end
    cur = mkb(0, 9'd127, 24'h800000, 3'b000, 5'd0, 0, 0, 0); push_val = model(cur);
    cur_valid = 1'b1;
    cyc();
    drain("post_rst_beat");

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      if (!(cur_valid && !acc)) begin
        cur_valid = ($urandom_range(0, 3) != 0);
        cur = rand_beat();
        push_val = model(cur);
      end
      cur_rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpaddsub_result_packer.md
# fpaddsub_result_packer

Final stage of the floating-point add/sub datapath: accepts the normalized sign/exponent/significand from the normalizer together with the input-exception vector produced at pre-alignment. It rounds, post-normalizes, and resolves special cases. It then reassembles an IEEE-754 single-precision word with status flags. It is a 2-stage valid/ready pipeline that is the packing counterpart of the pre-alignment unpacking.

## Interface
- No parameters; widths fixed to binary32.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat.
- in_sign  in  1  result sign from datapath.
- in_exp  in  9  biased exponent; bit 8 set = exponent overflow from normalizer.
- in_mant  in  24  normalized significand, hidden bit at [23]; all-zero = exact zero.
- in_grs  in  3  guard, round, sticky bits.
- in_exc  in  5  {any, ANaN, BNaN, AInf, BInf} from pre-alignment.
- in_sa, in_sb, in_op  in  1 each  original signs and operation (1 = subtract).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  packed binary32 result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

## Operation
- Stage 1 (round): register sign, exp, exc, signs/op. rnd_up = G & (R | S | mant[0]). Register 25-bit sum mant + rnd_up. inexact = |grs.
- Stage 2 (pack), priority order:
  - ANaN | BNaN → 0x7FC00000, flags 0.
  - AInf & BInf with eff_sub = sa ^ sb ^ op = 1 → 0x7FC00000, invalid=1.
  - AInf → {sa, 0xFF, 0}. BInf only → {sb ^ op, 0xFF, 0}. Flags 0.
  - mant == 0 and grs == 0 → {sign, 31'b0}, flags 0.
  - Rounding carry (sum[24]) → exp+1, fraction 0.
  - Final exp ≥ 255 or in_exp[8] → {sign, 0xFF, 0}, overflow=1, inexact=1.
  - Final exp == 0 → flush to {sign, 31'b0}, underflow=1, inexact=1. No denormals are produced.
  - Otherwise → {sign, exp[7:0], sum[22:0]}, inexact from stage 1.
- Exponent arithmetic is 9-bit unsigned. Overflow is checked after the rounding increment.

## Timing
- Latency is 2 cycles from accepted beat (in_valid & in_ready) to out_valid. Throughput is 1 beat/cycle.
- Global stall: adv = ~out_valid | out_ready. in_ready = adv.
- When adv = 0, both stages hold. out_data and out_flags stay stable while out_valid & ~out_ready.
- No bubble collapse: an empty stage 1 still stalls on a blocked stage 2.
- Reset value of all outputs and stage valids is 0; in_ready reads 1 after reset.
- Reset mid-operation discards in-flight beats. No out_valid appears until new input arrives.
- in_valid during stall is ignored; upstream must hold the beat.

## Configuration
- FPADDSUB_ROUND_NEAREST_EN defined: round-to-nearest-even as above.
- Macro undefined: truncation, rnd_up = 0. Inexact is still |grs, and overflow/underflow rules are unchanged.

## Structure
- A shared package fpaddsub_pkg holds:
  - the localparams EXP_W=8, MANT_W=23, BIAS=127, QNAN=32'h7FC00000, EXP_MAX=8'hFF;
  - an exception-vector bit-index enum (EXC_ANY, EXC_ANAN, EXC_BNAN, EXC_AINF, EXC_BINF);
  - the out_flags bit indices.
- One sub-module is natural: fpaddsub_round_unit, the combinational rnd_up and 25-bit sum logic, instantiated in stage 1.

## Test plan
- 1.0: in_exp=127, in_mant=0x800000, grs=0 → out_data 0x3F800000, flags 0, 2 cycles later.
- Tie rounds to even with carry: exp=127, mant=0xFFFFFF, grs=3'b100 → 0x40000000, inexact. Without macro → 0x3FFFFFFF, inexact.
- Overflow after rounding: exp=254, mant=0xFFFFFF, grs=3'b110 → 0x7F800000, flags {0,1,0,1}.
- Inf−Inf: in_exc=5'b10011, sa=sb=0, op=1 → 0x7FC00000, invalid=1. With op=0 → 0x7F800000, flags 0.
- Backpressure: issue 3 beats back-to-back and hold out_ready=0 for 4 cycles. out_data is stable, in_ready=0, and all 3 results emerge in order with none lost.
- Reset asserted with 2 beats in flight → out_valid=0 immediately. After release, in_ready=1 and no stale output appears.
